// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: FWFT FIFO with a valid/ready output,
// sticky overrun, almost-full flag and an idle-timeout pulse for short messages.
module uart_rx_fifo #(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 16,
    parameter int AW           = $clog2(DEPTH),
    parameter int ALMOST_FULL  = 12,
    parameter int IDLE_TIMEOUT = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [AW:0]       level,
    output logic              almost_full,
    output logic              overrun,
    input  logic              overrun_clr,
    output logic              timeout
);
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_LVL   = (AW + 1)'(ALMOST_FULL);
    localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       level_q;
    logic [AW:0]       level_nxt;
    logic [CW-1:0]     idle_cnt;
    logic              armed;
    logic              push;
    logic              pop;
    logic              drop;

    assign m_valid     = (level_q != '0);
    assign m_data      = mem[rd_ptr];
    assign level       = level_q;
    assign almost_full = (level_q >= AF_LVL);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop  = m_valid && m_ready;
    assign push = rx_ready && ((level_q != FULL_LVL) || pop);
    assign drop = rx_ready && !push;

    always_comb begin
        level_nxt = level_q;
        if (push && !pop) begin
            level_nxt = level_q + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            overrun  <= 1'b0;
            idle_cnt <= '0;
            armed    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= rx_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level_q <= level_nxt;

            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end

            // Draining to empty cancels a pending pulse; expiry disarms.
            timeout <= 1'b0;
            if (push) begin
                idle_cnt <= '0;
                armed    <= 1'b1;
            end else if (level_nxt == '0) begin
                idle_cnt <= '0;
                armed    <= 1'b0;
            end else if (armed && idle_cnt == IDLE_LAST) begin
                timeout  <= 1'b1;
                armed    <= 1'b0;
                idle_cnt <= '0;
            end else if (armed) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed and random traffic, expected bytes
// queued by a reference model and checked by a decoupled monitor.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int IT    = 40;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [4:0] level;
    logic       almost_full;
    logic       overrun;
    logic       overrun_clr;
    logic       timeout;

    uart_rx_fifo #(
        .DATA_W(8), .DEPTH(DEPTH), .ALMOST_FULL(AF), .IDLE_TIMEOUT(IT)
    ) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_ready(rx_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .level(level), .almost_full(almost_full),
        .overrun(overrun), .overrun_clr(overrun_clr),
        .timeout(timeout)
    );

    int compared   = 0;
    int mismatched = 0;
    int pulses     = 0;

    // Reference model state
    bit       started = 0;
    int       cnt     = 0;
    bit       m_ovr   = 0;
    bit       m_to    = 0;
    int       since   = 0;
    bit       live    = 0;
    logic [7:0] sb [$];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus "cycles since last accepted byte" bookkeeping.
    always @(posedge clk) begin
        bit mpop, mpush, mdrop;
        if (rst) begin
            started = 1;
            cnt = 0;
            sb.delete();
            m_ovr = 0;
            m_to = 0;
            since = 0;
            live = 0;
        end else if (started) begin
            mpop  = (cnt > 0) && m_ready;
            mpush = rx_ready && (cnt < DEPTH || mpop);
            mdrop = rx_ready && !mpush;
            if (mpush) sb.push_back(rx_data);
            cnt = cnt + int'(mpush) - int'(mpop);
            if (mdrop) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;
            m_to = 0;
            if (mpush) begin
                since = 0;
                live = 1;
            end else if (cnt == 0) begin
                live = 0;
            end else if (live) begin
                since++;
                if (since == IT) begin
                    m_to = 1;
                    live = 0;
                end
            end
        end
    end

    // Monitor: sample away from the active edge, pop expected on handshake.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        if (started) begin
            chk("level", int'(level), cnt);
            chk("m_valid", int'(m_valid), int'(cnt > 0));
            chk("almost_full", int'(almost_full), int'(cnt >= AF));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("timeout", int'(timeout), int'(m_to));
            if (timeout) pulses++;
            if (m_valid && m_ready && !rst) begin
                if (sb.size() == 0) begin
                    chk("pop_on_empty_model", 1, 0);
                end else begin
                    exp_b = sb.pop_front();
                    chk("m_data", int'(m_data), int'(exp_b));
                end
            end
        end
    end

    task automatic cyc(input logic rr, input logic [7:0] d,
                       input logic mr, input logic clr);
        rx_ready    = rr;
        rx_data     = d;
        m_ready     = mr;
        overrun_clr = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        int p1;
        rst = 1;
        rx_ready = 0;
        rx_data = 0;
        m_ready = 0;
        overrun_clr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        chk("reset_m_data", int'(m_data), 0);

        // Single byte in and out
        cyc(1, 8'hA5, 0, 0);
        chk("a5_visible", int'(m_data), 8'hA5);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Fill, overrun, clear race, full push+pop, drain
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0);
        cyc(1, 8'h77, 0, 0);
        cyc(1, 8'h78, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(1, 8'h99, 1, 0);
        repeat (DEPTH + 4) cyc(0, 0, 1, 0);

        // Idle timeout, then drain before expiry
        p0 = pulses;
        for (int i = 0; i < 3; i++) cyc(1, 8'(8'h30 + i), 0, 0);
        repeat (IT + 5) cyc(0, 0, 0, 0);
        chk("timeout_once", pulses - p0, 1);
        cyc(1, 8'h44, 0, 0);
        repeat (10) cyc(0, 0, 0, 0);
        repeat (5) cyc(0, 0, 1, 0);
        p1 = pulses;
        repeat (IT + 10) cyc(0, 0, 0, 0);
        chk("no_pulse_after_drain", pulses - p1, 0);

        // Random traffic in fill-heavy and drain-heavy phases
        for (int i = 0; i < 3000; i++) begin
            int pr;
            int pm;
            pr = (i % 600 < 300) ? 70 : 30;
            pm = (i % 600 < 300) ? 30 : 70;
            if ($urandom_range(0, 149) == 0) begin
                repeat (IT + 3) cyc(0, 0, 0, 0);
            end
            if ($urandom_range(0, 699) == 0) rst = 1;
            cyc($urandom_range(0, 99) < pr, 8'($urandom),
                $urandom_range(0, 99) < pm, $urandom_range(0, 19) == 0);
            rst = 0;
        end

        // Reset with bytes queued and overrun set
        repeat (DEPTH + 2) cyc(0, 0, 1, 0);
        for (int i = 0; i < DEPTH + 1; i++) cyc(1, 8'(8'hC0 + i), 0, 0);
        repeat (DEPTH - 5) cyc(0, 0, 1, 0);
        rst = 1;
        cyc(0, 0, 0, 0);
        rst = 0;
        chk("rst_level", int'(level), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_m_data", int'(m_data), 0);
        repeat (3) cyc(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end
endmodule
